// File: rtl/swc_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | swc_pkg                                                                  |
// | Shared OP-IMM encodings, strobe bundle and sequencer state encoding.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package swc_pkg;

   localparam logic [6:0] c_opc_opimm = 7'b0010011;

   localparam logic [2:0] c_f3_addi  = 3'b000;
   localparam logic [2:0] c_f3_slli  = 3'b001;
   localparam logic [2:0] c_f3_slti  = 3'b010;
   localparam logic [2:0] c_f3_sltiu = 3'b011;
   localparam logic [2:0] c_f3_xori  = 3'b100;
   localparam logic [2:0] c_f3_srxi  = 3'b101;
   localparam logic [2:0] c_f3_ori   = 3'b110;
   localparam logic [2:0] c_f3_andi  = 3'b111;

   localparam logic [6:0] c_f7_zero  = 7'b0000000;
   localparam logic [6:0] c_f7_srai  = 7'b0100000;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_EXEC  = 2'd2,
      ST_HALT  = 2'd3
   } state_t;

   typedef struct packed {
      logic addi;
      logic slti;
      logic sltiu;
      logic xori;
      logic ori;
      logic andi;
      logic slli;
      logic srli;
      logic srai;
   } dec_strb_t;

endpackage
`default_nettype wire

// File: rtl/ifu_opimm_dec.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ifu_opimm_dec                                                            |
// | Combinational OP-IMM decoder: one-hot strobes, legality, I-type fields.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module ifu_opimm_dec
   import swc_pkg::*;
(
   input  logic [31:0] instr,
   output dec_strb_t   strb,
   output logic        legal,
   output logic        is_opimm,
   output logic [11:0] imm_i,
   output logic [4:0]  rd,
   output logic [4:0]  rs1
);

   logic [2:0] w_funct3;
   logic [6:0] w_funct7;

   assign is_opimm = (instr[6:0] == c_opc_opimm);
   assign w_funct3 = instr[14:12];
   assign w_funct7 = instr[31:25];
   assign imm_i    = instr[31:20];
   assign rd       = instr[11:7];
   assign rs1      = instr[19:15];

   // Shift forms with a non-canonical funct7 leave every strobe low.
   always_comb begin
      strb = '0;
      if (is_opimm) begin
         case (w_funct3)
            c_f3_addi:  strb.addi  = 1'b1;
            c_f3_slti:  strb.slti  = 1'b1;
            c_f3_sltiu: strb.sltiu = 1'b1;
            c_f3_xori:  strb.xori  = 1'b1;
            c_f3_ori:   strb.ori   = 1'b1;
            c_f3_andi:  strb.andi  = 1'b1;
            c_f3_slli:  strb.slli  = (w_funct7 == c_f7_zero);
            c_f3_srxi: begin
               strb.srli = (w_funct7 == c_f7_zero);
               strb.srai = (w_funct7 == c_f7_srai);
            end
            default: strb = '0;
         endcase
      end
   end

   assign legal = (strb != '0);

endmodule
`default_nettype wire

// File: rtl/ifu_seq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ifu_seq_ctrl                                                             |
// | Fetch/execute-window sequencer with OP-IMM decode and pc override.       |
// | Optional: SWC_ILLEGAL_TRAP_EN halts on illegal OP-IMM encodings.         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module ifu_seq_ctrl
   import swc_pkg::*;
#(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int unsigned EXEC_CYCLES = 4
)(
   input  logic        hclk,
   input  logic        hrstn,
   output logic        ifu_req,
   output logic [31:0] ifu_addr,
   input  logic        ifu_rvalid,
   input  logic [31:0] ifu_rdata,
   input  logic        exu_stall,
   input  logic        pc_wen,
   input  logic [31:0] pc_wdata,
   output logic [31:0] pc,
   output logic [3:0]  cycle_cnt,
   output logic        dec_branch_en,
   output logic        dec_addi,
   output logic        dec_slti,
   output logic        dec_sltiu,
   output logic        dec_xori,
   output logic        dec_ori,
   output logic        dec_andi,
   output logic        dec_slli,
   output logic        dec_srli,
   output logic        dec_srai,
   output logic [11:0] dec_imm_type_i,
   output logic [4:0]  dec_rd,
   output logic [4:0]  dec_rs1,
   output logic        illegal
);

   localparam logic [3:0] c_last_cnt = 4'(EXEC_CYCLES);

   state_t      r_state;
   state_t      w_state_nxt;
   logic [31:0] r_pc;
   logic [31:0] r_instr;
   logic [3:0]  r_cnt;
   logic        r_ovr_vld;
   logic [31:0] r_ovr_pc;

   logic        w_exec;
   logic        w_fetch_done;
   logic        w_win_end;
   logic        w_trap;
   dec_strb_t   w_strb;
   logic        w_legal;
   logic        w_is_opimm;
   logic [11:0] w_imm;
   logic [4:0]  w_rd;
   logic [4:0]  w_rs1;

   ifu_opimm_dec u_dec (
      .instr    (r_instr),
      .strb     (w_strb),
      .legal    (w_legal),
      .is_opimm (w_is_opimm),
      .imm_i    (w_imm),
      .rd       (w_rd),
      .rs1      (w_rs1)
   );

   assign w_exec       = (r_state == ST_EXEC);
   assign w_fetch_done = (r_state == ST_FETCH) & ifu_rvalid;
   assign w_win_end    = w_exec & (r_cnt == c_last_cnt) & ~exu_stall;

`ifdef SWC_ILLEGAL_TRAP_EN
   logic r_ill;

   // Trap is taken in the first execute cycle, before any strobes could matter.
   assign w_trap = w_exec & (r_cnt == 4'd1) & w_is_opimm & ~w_legal;

   always_ff @(posedge hclk or negedge hrstn) begin
      if (!hrstn) begin
         r_ill <= 1'b0;
      end else if (w_trap) begin
         r_ill <= 1'b1;
      end
   end

   assign illegal = r_ill;
`else
   assign w_trap  = 1'b0;
   assign illegal = 1'b0;
`endif

   always_ff @(posedge hclk or negedge hrstn) begin
      if (!hrstn) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      ifu_req     = 1'b0;
      case (r_state)
         ST_IDLE:  w_state_nxt = ST_FETCH;
         ST_FETCH: begin
            ifu_req = 1'b1;
            if (ifu_rvalid) begin
               w_state_nxt = ST_EXEC;
            end
         end
         ST_EXEC: begin
            if (w_trap) begin
               w_state_nxt = ST_HALT;
            end else if (w_win_end) begin
               w_state_nxt = ST_FETCH;
            end
         end
         ST_HALT:  w_state_nxt = ST_HALT;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge hclk or negedge hrstn) begin
      if (!hrstn) begin
         r_pc      <= RESET_PC;
         r_instr   <= '0;
         r_cnt     <= '0;
         r_ovr_vld <= 1'b0;
         r_ovr_pc  <= '0;
      end else if (w_fetch_done) begin
         r_instr <= ifu_rdata;
         r_cnt   <= 4'd1;
      end else if (w_exec) begin
         if (w_trap || w_win_end) begin
            r_cnt <= '0;
         end else if (!exu_stall) begin
            r_cnt <= r_cnt + 4'd1;
         end
         // An override arriving in the closing cycle beats the latched one.
         if (w_win_end) begin
            r_pc      <= pc_wen    ? pc_wdata :
                         r_ovr_vld ? r_ovr_pc : r_pc + 32'd4;
            r_ovr_vld <= 1'b0;
         end else if (w_trap) begin
            r_ovr_vld <= 1'b0;
         end else if (pc_wen) begin
            r_ovr_vld <= 1'b1;
            r_ovr_pc  <= pc_wdata;
         end
      end
   end

   assign pc             = r_pc;
   assign ifu_addr       = r_pc;
   assign cycle_cnt      = r_cnt;
   assign dec_branch_en  = w_exec & w_legal;
   assign dec_addi       = w_exec & w_strb.addi;
   assign dec_slti       = w_exec & w_strb.slti;
   assign dec_sltiu      = w_exec & w_strb.sltiu;
   assign dec_xori       = w_exec & w_strb.xori;
   assign dec_ori        = w_exec & w_strb.ori;
   assign dec_andi       = w_exec & w_strb.andi;
   assign dec_slli       = w_exec & w_strb.slli;
   assign dec_srli       = w_exec & w_strb.srli;
   assign dec_srai       = w_exec & w_strb.srai;
   assign dec_imm_type_i = w_exec ? w_imm : 12'd0;
   assign dec_rd         = w_exec ? w_rd  : 5'd0;
   assign dec_rs1        = w_exec ? w_rs1 : 5'd0;

endmodule
`default_nettype wire

// File: tb/tb_ifu_seq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ifu_seq_ctrl                                                          |
// | Transaction-level model of fetch/execute windows with per-cycle compare. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_ifu_seq_ctrl;

   localparam int          EXEC   = 4;
   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic        hclk = 1'b0;
   logic        hrstn = 1'b0;
   logic        ifu_req;
   logic [31:0] ifu_addr;
   logic        ifu_rvalid = 1'b0;
   logic [31:0] ifu_rdata = '0;
   logic        exu_stall = 1'b0;
   logic        pc_wen = 1'b0;
   logic [31:0] pc_wdata = '0;
   logic [31:0] pc;
   logic [3:0]  cycle_cnt;
   logic        dec_branch_en, dec_addi, dec_slti, dec_sltiu, dec_xori;
   logic        dec_ori, dec_andi, dec_slli, dec_srli, dec_srai;
   logic [11:0] dec_imm_type_i;
   logic [4:0]  dec_rd, dec_rs1;
   logic        illegal;

   ifu_seq_ctrl #(.RESET_PC(RST_PC), .EXEC_CYCLES(EXEC)) dut (
      .hclk(hclk), .hrstn(hrstn), .ifu_req(ifu_req), .ifu_addr(ifu_addr),
      .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata), .exu_stall(exu_stall),
      .pc_wen(pc_wen), .pc_wdata(pc_wdata), .pc(pc), .cycle_cnt(cycle_cnt),
      .dec_branch_en(dec_branch_en), .dec_addi(dec_addi), .dec_slti(dec_slti),
      .dec_sltiu(dec_sltiu), .dec_xori(dec_xori), .dec_ori(dec_ori),
      .dec_andi(dec_andi), .dec_slli(dec_slli), .dec_srli(dec_srli),
      .dec_srai(dec_srai), .dec_imm_type_i(dec_imm_type_i), .dec_rd(dec_rd),
      .dec_rs1(dec_rs1), .illegal(illegal)
   );

   always #5 hclk = ~hclk;

   logic [8:0] act_strb;
   assign act_strb = {dec_addi, dec_slti, dec_sltiu, dec_xori, dec_ori,
                      dec_andi, dec_slli, dec_srli, dec_srai};

   int n_chk = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   logic        exp_req;
   logic [31:0] exp_pc;
   logic [3:0]  exp_cnt;
   logic [8:0]  exp_strb;
   logic        exp_be;
   logic [11:0] exp_imm;
   logic [4:0]  exp_rd, exp_rs1;
   logic        exp_ill;

   logic [31:0] m_pc;
   bit          m_ill;

   logic [31:0] s_addr;
   logic [8:0]  s_strb;
   logic [11:0] s_imm;
   logic [4:0]  s_rd;
   logic        s_be_any;
   int          n_exec;
   logic [3:0]  hist [0:31];
`ifdef SWC_ILLEGAL_TRAP_EN
   logic        s_ill;
`endif

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
      end
   endtask

   always @(negedge hclk) begin
      if (chk_en) begin
         cmp("ifu_req",   32'(ifu_req),        32'(exp_req));
         cmp("ifu_addr",  ifu_addr,            exp_pc);
         cmp("pc",        pc,                  exp_pc);
         cmp("cycle_cnt", 32'(cycle_cnt),      32'(exp_cnt));
         cmp("strobes",   32'(act_strb),       32'(exp_strb));
         cmp("branch_en", 32'(dec_branch_en),  32'(exp_be));
         cmp("imm",       32'(dec_imm_type_i), 32'(exp_imm));
         cmp("rd",        32'(dec_rd),         32'(exp_rd));
         cmp("rs1",       32'(dec_rs1),        32'(exp_rs1));
         cmp("illegal",   32'(illegal),        32'(exp_ill));
      end
   end

   // {illegal_opimm, addi,slti,sltiu,xori,ori,andi,slli,srli,srai}
   function automatic logic [9:0] ref_dec(input logic [31:0] ins);
      logic [8:0] s;
      logic       bad;
      logic [6:0] f7;
      s   = '0;
      bad = 1'b0;
      f7  = ins[31:25];
      if (ins[6:0] == 7'b0010011) begin
         case (ins[14:12])
            3'd0: s[8] = 1'b1;
            3'd2: s[7] = 1'b1;
            3'd3: s[6] = 1'b1;
            3'd4: s[5] = 1'b1;
            3'd6: s[4] = 1'b1;
            3'd7: s[3] = 1'b1;
            3'd1: if (f7 == 7'd0) s[2] = 1'b1; else bad = 1'b1;
            default: begin
               if (f7 == 7'd0)            s[1] = 1'b1;
               else if (f7 == 7'b0100000) s[0] = 1'b1;
               else                       bad  = 1'b1;
            end
         endcase
      end
      return {bad, s};
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] w;
      w = $urandom;
      if ($urandom_range(3, 0) != 0) w[6:0] = 7'b0010011;
      if (w[13:12] == 2'b01) begin
         case ($urandom_range(2, 0))
            0:       w[31:25] = 7'd0;
            1:       w[31:25] = 7'b0100000;
            default: ;
         endcase
      end
      return w;
   endfunction

   task automatic tick();
      @(posedge hclk);
      #1;
   endtask

   task automatic exp_quiet(input logic req);
      exp_req  = req;     exp_pc  = m_pc; exp_cnt = 4'd0; exp_strb = '0;
      exp_be   = 1'b0;    exp_imm = '0;   exp_rd  = '0;   exp_rs1  = '0;
      exp_ill  = m_ill;
   endtask

   task automatic do_reset();
      hrstn = 1'b0; ifu_rvalid = 1'b0; pc_wen = 1'b0; exu_stall = 1'b0;
      pc_wdata = '0; ifu_rdata = '0;
      m_pc = RST_PC; m_ill = 1'b0;
      exp_quiet(1'b0);
      chk_en = 1'b1;
      tick();
      cmp("rst_req", 32'(ifu_req), 32'd0);
      cmp("rst_pc", pc, RST_PC);
      cmp("rst_cnt", 32'(cycle_cnt), 32'd0);
      cmp("rst_ill", 32'(illegal), 32'd0);
      tick();
      hrstn = 1'b1;
      tick();
   endtask

   // Entered in the first FETCH cycle; returns in the next FETCH cycle,
   // or in HALT (halted) / with reset asserted mid-window (aborted).
   task automatic run_instr(input logic [31:0] ins, input int lat, input bit rnd,
                            input int st_at, input int st_len,
                            input int pw1_at, input logic [31:0] pw1_d,
                            input int pw2_at, input logic [31:0] pw2_d,
                            input int rst_at, output bit halted, output bit aborted);
      logic [9:0]  d;
      int          k, nx, st_done;
      bit          ovr, stl, pcw;
      logic [31:0] tgt, pcd;
      halted = 1'b0; aborted = 1'b0;
      d = ref_dec(ins);
      for (int i = 0; i <= lat; i++) begin
         exp_quiet(1'b1);
         if (i == 0) s_addr = ifu_addr;
         pc_wen     = 1'b0;
         exu_stall  = 1'($urandom_range(1, 0));
         ifu_rvalid = (i == lat);
         ifu_rdata  = (i == lat) ? ins : $urandom;
         tick();
      end
      ifu_rvalid = 1'b0;
      k = 1; nx = 0; st_done = 0; ovr = 1'b0; tgt = '0; s_be_any = 1'b0;
      forever begin
         exp_req  = 1'b0;        exp_pc  = m_pc;       exp_cnt = 4'(k);
         exp_strb = d[8:0];      exp_be  = |d[8:0];    exp_imm = ins[31:20];
         exp_rd   = ins[11:7];   exp_rs1 = ins[19:15]; exp_ill = m_ill;
         if (nx == 0) begin
            s_strb = act_strb; s_imm = dec_imm_type_i; s_rd = dec_rd;
         end
         if (nx < 32) hist[nx] = cycle_cnt;
         s_be_any = s_be_any | dec_branch_en;
         if (k == rst_at) begin
            #2 hrstn = 1'b0;
            #1;
            m_pc = RST_PC; m_ill = 1'b0;
            exp_quiet(1'b0);
            cmp("async_rst_pc", pc, RST_PC);
            cmp("async_rst_cnt", 32'(cycle_cnt), 32'd0);
            cmp("async_rst_req", 32'(ifu_req), 32'd0);
            cmp("async_rst_dec", {23'd0, act_strb}, 32'd0);
            cmp("async_rst_imm", 32'(dec_imm_type_i), 32'd0);
            aborted = 1'b1;
            return;
         end
         if (rnd) begin
            stl = ($urandom_range(3, 0) == 0);
            pcw = ($urandom_range(5, 0) == 0);
            pcd = $urandom;
         end else begin
            stl = (k == st_at) && (st_done < st_len);
            pcw = (k == pw1_at) || (k == pw2_at);
            pcd = (k == pw2_at) ? pw2_d : pw1_d;
         end
         if (stl) st_done++;
         exu_stall  = stl;
         pc_wen     = pcw;
         pc_wdata   = pcd;
         ifu_rvalid = rnd ? 1'($urandom_range(1, 0)) : 1'b0;
         ifu_rdata  = $urandom;
         nx++;
`ifdef SWC_ILLEGAL_TRAP_EN
         if (d[9]) begin
            tick();
            m_ill = 1'b1;
            for (int h = 0; h < 3; h++) begin
               exp_quiet(1'b0);
               if (h == 0) s_ill = illegal;
               ifu_rvalid = 1'($urandom_range(1, 0));
               pc_wen     = 1'($urandom_range(1, 0));
               pc_wdata   = $urandom;
               tick();
            end
            pc_wen = 1'b0; ifu_rvalid = 1'b0;
            n_exec = nx; halted = 1'b1;
            return;
         end
`endif
         if (pcw) begin
            ovr = 1'b1; tgt = pcd;
         end
         if (k == EXEC && !stl) begin
            m_pc   = ovr ? tgt : m_pc + 32'd4;
            n_exec = nx;
            tick();
            return;
         end
         if (!stl) k++;
         tick();
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      bit h, a;
      do_reset();

      run_instr(32'h0050_0093, 2, 1'b0, 0, 0, 0, 0, 0, 0, 0, h, a);
      cmp("addi_fetch_addr", s_addr, 32'h0);
      cmp("addi_strb", 32'(s_strb), 32'h100);
      cmp("addi_rd", 32'(s_rd), 32'd1);
      cmp("addi_imm", 32'(s_imm), 32'd5);
      cmp("addi_cnt_seq", 32'({hist[0], hist[1], hist[2], hist[3]}), 32'h1234);
      cmp("addi_next_pc", pc, 32'd4);
      cmp("addi_next_req", 32'(ifu_req), 32'd1);

      run_instr(32'h4031_5113, 1, 1'b0, 0, 0, 0, 0, 0, 0, 0, h, a);
      cmp("srai_strb", 32'(s_strb), 32'h001);
      cmp("srai_imm", 32'(s_imm), 32'h403);

      run_instr(32'h0050_0093, 0, 1'b0, 2, 3, 0, 0, 0, 0, 0, h, a);
      cmp("stall_window_len", 32'(n_exec), 32'd7);
      cmp("stall_hold", 32'(hist[4]), 32'd2);
      cmp("stall_resume", 32'(hist[5]), 32'd3);

      run_instr(32'h0010_8093, 1, 1'b0, 0, 0, 2, 32'h100, 4, 32'h200, 0, h, a);
      cmp("pcw_last_wins", ifu_addr, 32'h200);

      run_instr(32'h0000_0013, 0, 1'b0, 0, 0, 3, 32'hFFFF_FFFC, 0, 0, 0, h, a);
      cmp("pcw_to_top", pc, 32'hFFFF_FFFC);

      run_instr(32'h0000_0033, 1, 1'b0, 0, 0, 0, 0, 0, 0, 0, h, a);
      cmp("wrap_fetch_addr", s_addr, 32'hFFFF_FFFC);
      cmp("wrap_branch_en", 32'(s_be_any), 32'd0);
      cmp("wrap_cnt_seq", 32'({hist[0], hist[1], hist[2], hist[3]}), 32'h1234);
      cmp("wrap_pc", pc, 32'd0);

      run_instr(32'h0200_9093, 0, 1'b0, 0, 0, 0, 0, 0, 0, 0, h, a);
      cmp("illegal_strb", 32'(s_strb), 32'd0);
`ifdef SWC_ILLEGAL_TRAP_EN
      cmp("trap_illegal", 32'(s_ill), 32'd1);
      cmp("trap_pc_hold", pc, 32'd0);
      cmp("trap_no_req", 32'(ifu_req), 32'd0);
      do_reset();
`else
      cmp("nop_pc", pc, 32'd4);
      cmp("nop_illegal", 32'(illegal), 32'd0);
`endif

      run_instr(32'h0050_0093, 1, 1'b0, 0, 0, 0, 0, 0, 0, 2, h, a);
      do_reset();

      for (int n = 0; n < 150; n++) begin
         run_instr(rand_instr(), $urandom_range(3, 0), 1'b1, 0, 0, 0, 0, 0, 0,
                   ($urandom_range(19, 0) == 0) ? int'($urandom_range(4, 1)) : 0, h, a);
         if (h || a) do_reset();
      end

      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
